// File: rtl/imem_fetch_ctrl_pkg.sv
// imem_fetch_ctrl_pkg: shared state encoding and default geometry for the fetch controller
package imem_fetch_ctrl_pkg;
  typedef enum logic [1:0] {LOAD, RUN, HALT} state_e;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: loader stream, instruction memory and decode-side signals of the fetch controller
interface imem_fetch_ctrl_if import imem_fetch_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic ld_last;
  logic ld_ready;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic stall;
  logic branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic instr_valid;
  logic halted;
  logic [ADDR_W:0] load_count;
  modport master (
    input ld_valid, ld_data, ld_last, mem_rdata, stall, branch_taken, branch_target,
    output ld_ready, mem_we, mem_addr, mem_wdata, instr_out, pc_out, instr_valid, halted, load_count
  );
  modport slave (
    output ld_valid, ld_data, ld_last, mem_rdata, stall, branch_taken, branch_target,
    input ld_ready, mem_we, mem_addr, mem_wdata, instr_out, pc_out, instr_valid, halted, load_count
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: boot-loads instruction memory from a stream, then fetches with stall/branch until a halt word
module imem_fetch_ctrl import imem_fetch_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
  input logic clk,
  input logic reset,
  imem_fetch_ctrl_if.master bus
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, pc_q, pc_d, pc_out_q, pc_out_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic valid_q, valid_d;
  logic in_load;
  assign in_load = state_q == LOAD;
  assign bus.ld_ready = in_load;
  assign bus.mem_we = in_load & bus.ld_valid;
  assign bus.mem_addr = in_load ? waddr_q : pc_q;
  assign bus.mem_wdata = bus.ld_data;
  assign bus.instr_out = instr_q;
  assign bus.pc_out = pc_out_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted = state_q == HALT;
  assign bus.load_count = cnt_q;
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    pc_d = pc_q;
    cnt_d = cnt_q;
    instr_d = instr_q;
    pc_out_d = pc_out_q;
    valid_d = valid_q;
    if (state_q == LOAD) begin
      if (bus.ld_valid) begin
        waddr_d = waddr_q + ADDR_W'(1);
        cnt_d = cnt_q[ADDR_W] ? cnt_q : cnt_q + (ADDR_W+1)'(1);
        if (bus.ld_last || &waddr_q) begin
          state_d = RUN;
          pc_d = '0;
        end
      end
    end else if (state_q == RUN) begin
      if (bus.branch_taken) begin
        pc_d = bus.branch_target;
        valid_d = 1'b0;
      end else if (!bus.stall) begin
        instr_d = bus.mem_rdata;
        pc_out_d = pc_q;
        valid_d = 1'b1;
        // the halt word is delivered to decode but the PC parks on it
        if (bus.mem_rdata == HALT_WORD) state_d = HALT;
        else pc_d = pc_q + ADDR_W'(1);
      end
    end else begin
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      waddr_q <= '0;
      pc_q <= '0;
      cnt_q <= '0;
      instr_q <= '0;
      pc_out_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      instr_q <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Sequences the 64x32 asynchronous-read instruction memory. After reset it runs a boot-load phase: instruction words arrive on a valid/ready stream and are written to consecutive addresses from 0. It then switches to a fetch phase. There it owns the PC, applies stall and branch redirect, and presents registered instruction/PC pairs to decode. It halts on a configurable halt word.

Parameters:
ADDR_W, 6, word-address width of instruction memory (depth 2**ADDR_W)
DATA_W, 32, instruction width
HALT_WORD, 32'hFFFF_FFFF, fetched value that stops fetch

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
ld_valid  in  1  loader word valid
ld_data  in  DATA_W  loader word
ld_last  in  1  marks final loader word
ld_ready  out  1  controller accepts loader word
mem_we  out  1  instruction memory write enable
mem_addr  out  ADDR_W  memory address (write addr in LOAD, PC in RUN)
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory async read data at mem_addr
stall  in  1  hold fetch (decode back-pressure)
branch_taken  in  1  redirect request
branch_target  in  ADDR_W  redirect word address
instr_out  out  DATA_W  registered fetched instruction
pc_out  out  ADDR_W  word address of instr_out
instr_valid  out  1  instr_out/pc_out valid this cycle
halted  out  1  high in HALT state
load_count  out  ADDR_W+1  number of words loaded

Behaviour:
- Reset is synchronous and active-high. Clock port clk, reset port reset. A reset asserted at any time, including mid-load or mid-fetch, returns to LOAD next edge.
- Reset values: state=LOAD, waddr=0, pc=0, load_count=0, instr_out=0, pc_out=0, instr_valid=0, halted=0.
- States: LOAD, RUN, HALT (encoding from shared package).
- LOAD:
  - ld_ready=1 (combinational from state).
  - mem_we=ld_valid, mem_addr=waddr, mem_wdata=ld_data.
  - On handshake (ld_valid&ld_ready): waddr++, load_count++.
  - Go to RUN when the handshake has ld_last=1, or when the write lands on address 2**ADDR_W-1 (memory full; later ld_valid is not accepted because ld_ready=0 outside LOAD).
  - load_count saturates at 2**ADDR_W. pc=0 on entry to RUN.
- RUN:
  - mem_we=0, mem_addr=pc, ld_ready=0.
  - Priority each cycle: branch_taken > stall > normal.
  - branch_taken: pc<=branch_target; instr_valid<=0 (one-cycle bubble); instr_out/pc_out hold. Branch wins over a simultaneous stall.
  - stall (no branch): pc, instr_out, pc_out, instr_valid all hold.
  - Normal: instr_out<=mem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+1. pc wraps from 2**ADDR_W-1 to 0.
  - Fetch latency is 1 cycle from the pc value to instr_out.
- Halt condition, normal cycle only: if mem_rdata==HALT_WORD, the halt word is still captured (instr_valid<=1 that cycle), pc is not incremented, and state goes to HALT.
- HALT:
  - halted=1.
  - instr_valid<=0 on the first HALT cycle and stays 0.
  - pc, instr_out and pc_out are frozen.
  - Only reset exits HALT.
- mem_we is 0 in RUN and HALT regardless of inputs.
- stall and branch inputs are ignored in LOAD and HALT.

Decomposition:
- Shared package: state enum (LOAD, RUN, HALT), ADDR_W/DATA_W defaults, HALT_WORD constant.
- No sub-module needed. Optionally split the PC next-value logic (wrap, branch, stall mux) into pc_next_sel.

Test Plan:
- Load words 0x11,0x22,0x33 with ld_last on third -> mem writes at addr 0,1,2; load_count=3; RUN next cycle; instr_out 0x11,0x22,0x33 with pc_out 0,1,2 on consecutive cycles.
- Load 64 words without ld_last -> auto RUN after write to addr 63; ld_ready=0 thereafter; load_count=64.
- In RUN at pc=5, assert stall 3 cycles -> instr_out/pc_out/instr_valid frozen 3 cycles, then resumes at pc_out=5.
- In RUN, branch_taken with target=40 and stall simultaneous -> next cycle instr_valid=0; following cycle pc_out=40.
- Load HALT_WORD at addr 2 -> instr_valid for pc_out 0,1,2, then halted=1, instr_valid=0, pc_out stays 2; a branch request then has no effect.
- Assert reset mid-load (after 2 words) and again in HALT -> state LOAD, load_count=0, all outputs at reset values next cycle; reload from addr 0 works.
